// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, flag bit positions and FSM state encoding.
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD   = 3'b000;
  localparam opcode_t OP_SUB   = 3'b001;
  localparam opcode_t OP_AND   = 3'b010;
  localparam opcode_t OP_SHIFT = 3'b011;
  localparam opcode_t OP_MUL   = 3'b100;
  localparam opcode_t OP_OR    = 3'b110;
  localparam opcode_t OP_XOR   = 3'b111;

  localparam int FLG_NEG  = 0;
  localparam int FLG_POS  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_OVF  = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative signed shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;
  logic               last;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     upper;

  assign last = busy_reg && (cnt_reg == CW'(WIDTH - 1));

  // The multiplier sign bit carries weight -2^(WIDTH-1), so its partial product is subtracted.
  always_comb begin
    pp       = mplier_reg[0] ? mcand_reg : '0;
    acc_next = (cnt_reg == CW'(WIDTH - 1)) ? (acc_reg - pp) : (acc_reg + pp);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{a[WIDTH-1]}}, a};
      mplier_reg <= b;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= last ? '0 : (cnt_reg + CW'(1));
      if (last) begin
        busy_reg <= 1'b0;
      end
    end
  end

  // Product fits WIDTH signed bits only if the top WIDTH+1 bits are all equal.
  assign upper   = acc_next[2*WIDTH-1:WIDTH-1];
  assign done    = last;
  assign product = acc_next[WIDTH-1:0];
  assign ovf     = !((&upper) || !(|upper));

endmodule

// File: rtl/alu_seq.sv
// Handshaked registered ALU: single-cycle ops complete in one cycle, MUL runs through the iterative multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [WIDTH-1:0] i_arg0,
  input  logic signed [WIDTH-1:0] i_arg1,
  input  logic [2:0]              i_oper,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [WIDTH-1:0] o_result,
  output logic [3:0]              o_flag
);

  logic [1:0]              state_reg;
  logic signed [WIDTH-1:0] result_reg;
  logic [3:0]              flag_reg;
  logic [3:0]              flag_next;

  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;
  logic signed [WIDTH-1:0] shl;
  logic signed [WIDTH-1:0] shr;
  logic [WIDTH:0]          shamt;
  logic                    shamt_big;
  logic signed [WIDTH-1:0] alu_result;
  logic                    alu_ovf;
  logic signed [WIDTH-1:0] load_result;
  logic                    load_ovf;

  logic                    mul_start;
  logic                    mul_done;
  logic [WIDTH-1:0]        mul_product;
  logic                    mul_ovf;

  assign mul_start = (state_reg == IDLE) && i_valid && (i_oper == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .start   (mul_start),
    .a       (i_arg0),
    .b       (i_arg1),
    .done    (mul_done),
    .product (mul_product),
    .ovf     (mul_ovf)
  );

  // Shift magnitude needs one extra bit so that negating the most negative amount stays positive.
  always_comb begin
    sum       = i_arg0 + i_arg1;
    diff      = i_arg0 - i_arg1;
    shamt     = i_arg1[WIDTH-1] ? -{i_arg1[WIDTH-1], i_arg1} : {1'b0, i_arg1};
    shamt_big = (shamt >= (WIDTH+1)'(WIDTH));
    shl       = i_arg0 <<< shamt;
    shr       = i_arg0 >>> shamt;
  end

  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (i_oper)
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = (i_arg0[WIDTH-1] == i_arg1[WIDTH-1]) && (sum[WIDTH-1] != i_arg0[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = (i_arg0[WIDTH-1] != i_arg1[WIDTH-1]) && (diff[WIDTH-1] != i_arg0[WIDTH-1]);
      end
      OP_AND: alu_result = i_arg0 & i_arg1;
      OP_OR:  alu_result = i_arg0 | i_arg1;
      OP_XOR: alu_result = i_arg0 ^ i_arg1;
      OP_SHIFT: begin
        if (i_arg1[WIDTH-1]) begin
          alu_result = shamt_big ? {WIDTH{i_arg0[WIDTH-1]}} : shr;
        end else begin
          alu_result = shamt_big ? '0 : shl;
        end
      end
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    load_result          = (state_reg == MUL) ? mul_product : alu_result;
    load_ovf             = (state_reg == MUL) ? mul_ovf : alu_ovf;
    flag_next            = '0;
    flag_next[FLG_NEG]   = load_result[WIDTH-1];
    flag_next[FLG_ZERO]  = (load_result == '0);
    flag_next[FLG_POS]   = !load_result[WIDTH-1] && (load_result != '0);
    flag_next[FLG_OVF]   = load_ovf;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      flag_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_valid) begin
            if (i_oper == OP_MUL) begin
              state_reg <= MUL;
            end else begin
              state_reg  <= DONE;
              result_reg <= load_result;
              flag_reg   <= flag_next;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            state_reg  <= DONE;
            result_reg <= load_result;
            flag_reg   <= flag_next;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state_reg == IDLE);
  assign o_valid  = (state_reg == DONE);
  assign o_result = result_reg;
  assign o_flag   = flag_reg;

endmodule
